multicycle_ripple_adder: RTL and testbench
==========================================

MULTICYCLE_RIPPLE_ADDER -- requirements
Module: multicycle_ripple_adder

Interface
REQ-001 SHALL have parameter N, default 8: operand width in bits.
REQ-002 SHALL have parameter W, default 2: bits added per cycle (chunk width); legal only when N >= 1, 1 <= W <= N and N mod W == 0.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operands a, b and cin valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  N  addend.
REQ-008 SHALL have port b  input  N  addend.
REQ-009 SHALL have port cin  input  1  carry in.
REQ-010 SHALL have port out_valid  output  1  sum and cout valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port sum  output  N  result, (a + b + cin) mod 2^N.
REQ-013 SHALL have port cout  output  1  carry out of bit N-1.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 IDLE: on an edge with in_valid=1, SHALL capture a, b and cin into internal registers (carry register := cin), clear chunk index to 0, clear the sum register, and go to RUN; otherwise stay in IDLE.
REQ-016 RUN: each edge SHALL compute a[idx*W +: W] + b[idx*W +: W] + carry register, write the low W bits to sum[idx*W +: W] and the carry out to the carry register, then increment idx.
REQ-017 RUN: on the edge that processes chunk N/W-1, SHALL move to DONE and load cout from the final chunk carry.
REQ-018 Latency: if operands are accepted on edge E0, out_valid SHALL be 1 from edge E0+N/W onward; with N=8, W=2 that is 4 edges.
REQ-019 DONE: sum and cout SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 DONE: on an edge with out_ready=1, SHALL go to IDLE; a new operand set is accepted no earlier than the following edge, so the minimum initiation interval is N/W+2 cycles.
REQ-021 in_valid while in RUN or DONE SHALL be ignored and SHALL NOT alter the captured operands or the result.
REQ-022 Changes on a, b or cin after capture SHALL NOT affect the result.
REQ-023 When W == N, SHALL spend exactly one cycle in RUN.
REQ-024 Result SHALL equal the N+1-bit value a + b + cin exactly: {cout, sum}.
REQ-025 In IDLE, sum and cout SHALL retain the last completed result.

Reset
REQ-026 On an edge with rst=1, SHALL enter IDLE and clear the sum register, cout, the carry register and idx to 0, giving in_ready=1 and out_valid=0 after that edge.
REQ-027 rst SHALL take priority over every other input in every state; a transaction in RUN or DONE is discarded and never reported.
REQ-028 in_valid sampled on a reset edge SHALL NOT be captured.

Verification
REQ-029 N=8, W=2: a=8'h0F, b=8'h01, cin=0 accepted on E0 -> out_valid from E4, sum=8'h10, cout=0.
REQ-030 a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1, with the carry rippling through all 4 chunks.
REQ-031 a=8'hA5, b=8'h5A, cin=0, out_ready held 0 for 5 cycles -> sum=8'hFF and cout=0 held stable and out_valid held high; in_ready returns to 1 the edge after out_ready=1.
REQ-032 Reset asserted 2 cycles into RUN -> IDLE next edge, out_valid never asserted, sum=0; the next transaction 8'h80+8'h80, cin=0 gives sum=8'h00, cout=1.
REQ-033 in_valid pulsed during RUN with different operands -> ignored, and the original result is unchanged.
REQ-034 Random regression for configurations (N=8,W=2), (N=8,W=8), (N=12,W=3), (N=1,W=1) checked against the {cout,sum} reference model, with random in_valid/out_ready stalls.

Source files
------------

// File: rtl/multicycle_ripple_adder.sv
// Multicycle ripple adder: adds two N-bit operands plus carry-in, W bits per cycle.
// Latency: N/W cycles from operand acceptance to out_valid; initiation interval N/W+2.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
//
// Ports:
//   clk, rst          - single clock, synchronous active-high reset
//   in_valid/in_ready - operand handshake (a, b, cin)
//   out_valid/out_ready - result handshake (sum, cout)
//   sum, cout         - {cout, sum} = a + b + cin; retained in IDLE until next capture
module multicycle_ripple_adder #(
  parameter int N = 8,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int NCH = N / W;
  // idx needs at least one bit even when the whole add fits in a single chunk
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  state_t        state_nxt;

  logic [N-1:0]  a_r;
  logic [N-1:0]  b_r;
  logic [N-1:0]  sum_r;
  logic          carry_r;
  logic          cout_r;
  logic [IW-1:0] idx;

  logic [W-1:0]  a_chunk;
  logic [W-1:0]  b_chunk;
  logic [W:0]    chunk_res;
  logic          last_chunk;

  // Chunk select written as a constant-index mux so every slice is static
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < NCH; k++) begin
      if (idx == IW'(k)) begin
        a_chunk = a_r[k*W +: W];
        b_chunk = b_r[k*W +: W];
      end
    end
    chunk_res  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{W{1'b0}}, carry_r};
    last_chunk = (idx == IW'(NCH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_chunk) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // cout keeps the previous result until the new one completes
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            sum_r   <= '0;
            idx     <= '0;
          end
        end
        RUN: begin
          for (int k = 0; k < NCH; k++) begin
            if (idx == IW'(k)) begin
              sum_r[k*W +: W] <= chunk_res[W-1:0];
            end
          end
          carry_r <= chunk_res[W];
          if (last_chunk) begin
            cout_r <= chunk_res[W];
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_multicycle_ripple_adder.sv
// Bench for multicycle_ripple_adder: directed vectors on (8,2) plus random
// traffic on (8,2), (8,8), (12,3) and (1,1) with handshake stalls.
module tb_multicycle_ripple_adder;

  localparam int NS [4] = '{8, 8, 12, 1};
  localparam int WS [4] = '{2, 8, 3, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] a_all;
  logic [11:0] b_all;
  logic        cin_all;
  logic [3:0]  iv;
  logic [3:0]  ordy;

  logic [3:0]  ir;
  logic [3:0]  ov;
  logic [7:0]  sum0;
  logic [7:0]  sum1;
  logic [11:0] sum2;
  logic [0:0]  sum3;
  logic [3:0]  co;

  int          cur;
  logic [11:0] obs_sum;
  logic        obs_cout;
  logic        obs_ir;
  logic        obs_ov;

  int          checks = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  multicycle_ripple_adder #(.N(8), .W(2)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_all[7:0]), .b(b_all[7:0]), .cin(cin_all),
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sum0), .cout(co[0]));

  multicycle_ripple_adder #(.N(8), .W(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_all[7:0]), .b(b_all[7:0]), .cin(cin_all),
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sum1), .cout(co[1]));

  multicycle_ripple_adder #(.N(12), .W(3)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_all), .b(b_all), .cin(cin_all),
    .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sum2), .cout(co[2]));

  multicycle_ripple_adder #(.N(1), .W(1)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]),
    .a(a_all[0:0]), .b(b_all[0:0]), .cin(cin_all),
    .out_valid(ov[3]), .out_ready(ordy[3]), .sum(sum3), .cout(co[3]));

  always_comb begin
    obs_sum  = '0;
    obs_cout = 1'b0;
    obs_ir   = 1'b0;
    obs_ov   = 1'b0;
    case (cur)
      0: begin obs_sum = {4'b0, sum0};  obs_cout = co[0]; obs_ir = ir[0]; obs_ov = ov[0]; end
      1: begin obs_sum = {4'b0, sum1};  obs_cout = co[1]; obs_ir = ir[1]; obs_ov = ov[1]; end
      2: begin obs_sum = sum2;          obs_cout = co[2]; obs_ir = ir[2]; obs_ov = ov[2]; end
      default: begin obs_sum = {11'b0, sum3}; obs_cout = co[3]; obs_ir = ir[3]; obs_ov = ov[3]; end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: plain (N+1)-bit addition, returns {cout, sum} right-aligned
  function automatic logic [12:0] ref_add(input int n, input logic [11:0] av,
                                          input logic [11:0] bv, input logic ci);
    logic [12:0] m;
    logic [12:0] full;
    m    = (13'd1 << n) - 13'd1;
    full = {1'b0, av & m[11:0]} + {1'b0, bv & m[11:0]} + {12'b0, ci};
    return full;
  endfunction

  // One complete transaction on instance cfg: accept, check latency and result,
  // hold out_ready low for `stall` cycles, then drain and check the return to IDLE.
  task automatic run_txn(input int cfg, input logic [11:0] av, input logic [11:0] bv,
                         input logic ci, input logic [11:0] es, input logic ec,
                         input int stall, input bit noisy, input string tag);
    int cyc;
    cur = cfg;
    repeat ($urandom_range(0, 1)) @(negedge clk);
    cyc = 0;
    while (!obs_ir && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_rdy"}, {31'b0, obs_ir}, 32'd1);
    a_all   = av;
    b_all   = bv;
    cin_all = ci;
    iv[cfg] = 1'b1;
    @(negedge clk);
    iv[cfg] = 1'b0;
    // operands change after capture and must not matter
    a_all   = 12'($urandom);
    b_all   = 12'($urandom);
    cin_all = ~ci;
    cyc = 0;
    while (!obs_ov && cyc < 40) begin
      if (noisy) begin
        iv[cfg] = 1'($urandom_range(0, 1));
        a_all   = 12'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    iv[cfg] = 1'b0;
    chk({tag, "_lat"}, 32'(cyc), 32'(NS[cfg] / WS[cfg]));
    chk({tag, "_sum"}, {20'b0, obs_sum}, {20'b0, es});
    chk({tag, "_cout"}, {31'b0, obs_cout}, {31'b0, ec});
    for (int s = 0; s < stall; s++) begin
      if (noisy) begin
        iv[cfg] = 1'($urandom_range(0, 1));
        b_all   = 12'($urandom);
      end
      @(negedge clk);
      chk({tag, "_hold_vld"}, {31'b0, obs_ov}, 32'd1);
      chk({tag, "_hold_sum"}, {20'b0, obs_sum}, {20'b0, es});
      chk({tag, "_hold_cout"}, {31'b0, obs_cout}, {31'b0, ec});
    end
    iv[cfg]   = 1'b0;
    ordy[cfg] = 1'b1;
    @(negedge clk);
    ordy[cfg] = 1'b0;
    chk({tag, "_idle_rdy"}, {31'b0, obs_ir}, 32'd1);
    chk({tag, "_idle_vld"}, {31'b0, obs_ov}, 32'd0);
    chk({tag, "_idle_sum"}, {20'b0, obs_sum}, {20'b0, es});
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] r;
    logic [11:0] ra;
    logic [11:0] rb;
    logic        rc;
    logic [12:0] m;

    cur     = 0;
    rst     = 1'b1;
    iv      = '0;
    ordy    = '0;
    a_all   = '0;
    b_all   = '0;
    cin_all = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", {31'b0, obs_ir}, 32'd1);
    chk("rst_vld", {31'b0, obs_ov}, 32'd0);
    chk("rst_sum", {20'b0, obs_sum}, 32'd0);
    chk("rst_cout", {31'b0, obs_cout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors on the default configuration
    run_txn(0, 12'h00F, 12'h001, 1'b0, 12'h010, 1'b0, 0, 1'b0, "t_0f_01");
    run_txn(0, 12'h0FF, 12'h000, 1'b1, 12'h000, 1'b1, 0, 1'b0, "t_ff_00_c");

    // Reset two cycles into RUN, with in_valid high on the reset edges
    cur = 0;
    a_all = 12'h012; b_all = 12'h034; cin_all = 1'b0; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    chk("mid_run_rdy", {31'b0, obs_ir}, 32'd0);
    repeat (2) @(negedge clk);
    chk("mid_run_vld", {31'b0, obs_ov}, 32'd0);
    rst = 1'b1;
    iv[0] = 1'b1;
    @(negedge clk);
    chk("mid_rst_rdy", {31'b0, obs_ir}, 32'd1);
    chk("mid_rst_vld", {31'b0, obs_ov}, 32'd0);
    chk("mid_rst_sum", {20'b0, obs_sum}, 32'd0);
    chk("mid_rst_cout", {31'b0, obs_cout}, 32'd0);
    @(negedge clk);
    chk("rst_iv_ignored", {31'b0, obs_ir}, 32'd1);
    rst = 1'b0;
    iv[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("discarded_vld", {31'b0, obs_ov}, 32'd0);
    end
    run_txn(0, 12'h080, 12'h080, 1'b0, 12'h000, 1'b1, 0, 1'b0, "t_80_80");

    // Held result under out_ready=0, then in_valid noise during RUN/DONE
    run_txn(0, 12'h0A5, 12'h05A, 1'b0, 12'h0FF, 1'b0, 5, 1'b0, "t_a5_5a_stall");
    run_txn(0, 12'h033, 12'h044, 1'b0, 12'h077, 1'b0, 2, 1'b1, "t_noisy");

    // Directed edges for the other configurations
    run_txn(1, 12'h0FF, 12'h0FF, 1'b1, 12'h0FF, 1'b1, 1, 1'b0, "t_w8_max");
    run_txn(2, 12'hFFF, 12'h000, 1'b1, 12'h000, 1'b1, 0, 1'b0, "t_n12_ripple");
    run_txn(3, 12'h001, 12'h001, 1'b1, 12'h001, 1'b1, 0, 1'b0, "t_n1_max");

    // Random regression across all configurations
    for (int cfg = 0; cfg < 4; cfg++) begin
      for (int t = 0; t < 15; t++) begin
        m  = (13'd1 << NS[cfg]) - 13'd1;
        ra = 12'($urandom) & m[11:0];
        rb = 12'($urandom) & m[11:0];
        rc = 1'($urandom_range(0, 1));
        r  = ref_add(NS[cfg], ra, rb, rc);
        run_txn(cfg, ra, rb, rc, r[11:0] & m[11:0], r[NS[cfg]],
                $urandom_range(0, 3), 1'b1, "rnd");
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
